// File: rtl/uart_char_receiver.sv
// ---------------------------------------------------------------------------
// uart_char_receiver
//
// Recovers 8N1 UART frames from an asynchronous RX pin and presents each
// correctly framed byte on a held 8-bit output feeding the 7-segment
// character encoder. The output keeps the last good byte so the display
// stays stable between frames.
//
// Ports:
//   clk           - system clock, all state changes on the rising edge
//   reset_n       - asynchronous active-low reset
//   rx            - serial line, idle high, asynchronous to clk
//   char_out      - last correctly framed byte (8'h00 after reset)
//   char_valid    - one-cycle pulse when char_out is updated
//   framing_error - one-cycle pulse when the stop bit samples low
//   busy          - high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_char_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shreg_reg, shreg_next;
  logic [7:0]      char_reg, char_next;
  logic            valid_reg, valid_next;
  logic            ferr_reg, ferr_next;

  // Two-flop synchronizer; both stages reset to the idle line level so a
  // reset release never looks like a start bit.
  logic            rx_meta_reg;
  logic            rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s        <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shreg_reg   <= '0;
      char_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shreg_reg   <= shreg_next;
      char_reg    <= char_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shreg_next   = shreg_reg;
    char_next    = char_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (!rx_s) begin
          state_next = S_START;
          cnt_next   = '0;
        end
      end

      S_START: begin
        // Re-check the line at the middle of the start bit; a high level
        // here means the falling edge was noise.
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next                = '0;
          shreg_next[bit_idx_reg] = rx_s;
          bit_idx_next            = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            char_next  = shreg_reg;
            valid_next = 1'b1;
            state_next = S_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = S_WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_WAIT_IDLE: begin
        // A held-low line (break) must return high before a new frame is
        // accepted, otherwise it would decode as a stream of 8'h00 frames.
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign char_out      = char_reg;
  assign char_valid    = valid_reg;
  assign framing_error = ferr_reg;
  assign busy          = (state_reg != S_IDLE);

endmodule

// File: doc/uart_char_receiver.md
# uart_char_receiver

Serial-to-parallel receive stage that recovers 8N1 UART frames from the board RX pin and presents each received ASCII byte on a held 8-bit output. It sits directly upstream of the 7-segment character encoder: `char_out` drives the encoder's 8-bit character input. `char_out` holds the last good byte, so the display stays stable between frames. Single clock domain; the RX pin is asynchronous to it.

## Interface
- `CLKS_PER_BIT`, default 434: system clocks per serial bit (50 MHz / 115200 baud). Legal range is ≥ 4; the half-bit point is `CLKS_PER_BIT/2` (integer division).
- `clk` in, 1: system clock; all state changes on the rising edge.
- `reset_n` in, 1: one clock; reset is asynchronous and active-low.
- `rx` in, 1: serial line, idle high, asynchronous to `clk`.
- `char_out` out, 8: last correctly framed byte (ASCII); held until the next good frame.
- `char_valid` out, 1: one-cycle pulse when `char_out` is updated.
- `framing_error` out, 1: one-cycle pulse when the stop bit samples low.
- `busy` out, 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). All decisions use `rx_s`. The synchronizer flops reset to 1.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when `rx_s == 0`, go to START and clear the bit counter `cnt`.
- START: increment `cnt`. At `cnt == CLKS_PER_BIT/2 - 1`, check `rx_s`:
  - If 0: go to DATA with `cnt = 0` and `bit_idx = 0`.
  - If 1: treat as a glitch and return to IDLE. No output pulse.
- DATA: at `cnt == CLKS_PER_BIT-1`, shift `rx_s` into `shreg[bit_idx]` (LSB first), clear `cnt`, and increment `bit_idx`. After bit 7 is sampled, go to STOP.
- STOP: at `cnt == CLKS_PER_BIT-1`, sample `rx_s`:
  - If 1: load `char_out <= shreg`, pulse `char_valid`, go to IDLE.
  - If 0: pulse `framing_error`, leave `char_out` unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s == 1`, then go to IDLE. This prevents a break condition (line held low) from being re-read as back-to-back frames.
- `char_valid` and `framing_error` are never high in the same cycle and never high for more than one cycle per frame.
- `cnt` width is `$clog2(CLKS_PER_BIT)`. `cnt` never exceeds `CLKS_PER_BIT-1`.

## Timing
- Reset values:
  - FSM: IDLE.
  - `char_out`: 8'h00, which the downstream encoder shows as a dash.
  - `char_valid`, `framing_error`, `busy`: 0.
  - `shreg`, `cnt`, `bit_idx`: 0.
  - Synchronizer flops: 1.
- `reset_n` low mid-frame aborts immediately to the reset state. There is no partial update of `char_out`. After release, reception resumes at the next falling edge seen in IDLE.
- Input latency: 2 clocks from an `rx` change to the corresponding `rx_s` change.
- Sample points relative to START entry:
  - Start bit: clock `CLKS_PER_BIT/2`.
  - Data bit k: clock `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
  - Stop bit: clock `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
- `char_valid` / `framing_error` and the new `char_out` are registered and visible the edge after the stop-bit sample.
- `busy` rises the cycle after START entry and falls in the same cycle as the `char_valid` pulse. For a framing error, it falls on exit from WAIT_IDLE.
- Back-to-back frames: a start bit beginning immediately after the stop bit's mid-point is accepted. The FSM is back in IDLE 1 clock after the stop sample, which is well inside the remaining half stop bit.
- Tolerated baud mismatch: ±4% (mid-bit sampling).

## Test plan
Use `CLKS_PER_BIT = 8` for simulation.

- Reset: hold `reset_n = 0` with `rx = 1`, then release. Expect `char_out = 8'h00`, `char_valid = 0`, `framing_error = 0`, `busy = 0`.
- Good frame 'A' (8'h41, bits 1,0,0,0,0,0,1,0, stop 1). Expect:
  - exactly one `char_valid` pulse;
  - `char_out = 8'h41` from that cycle onward;
  - `framing_error` never asserted.
- Back-to-back '3' (8'h33), then 'F' (8'h46), with no idle gap. Expect:
  - two `char_valid` pulses 80 clocks apart;
  - `char_out` goes 8'h33 → 8'h46.
- Glitch rejection: drive `rx` low for 2 clocks, then high. Expect the FSM back in IDLE with no pulses and `char_out` unchanged.
- Framing error: send 8'h39 with stop bit 0, keep `rx` low for 30 more clocks, then high, then send 8'h37. Expect:
  - one `framing_error` pulse;
  - `char_out` keeps its prior value during the error;
  - no frames decoded while the line is held low;
  - then `char_valid` with `char_out = 8'h37`.
- Reset mid-frame: assert `reset_n = 0` during data bit 4 of 8'h45. Expect `char_out = 8'h00` and no `char_valid`. After release, a full 8'h45 frame is received correctly.
